// File: rtl/pos_cell_reader.sv
// pos_cell_reader: reads one position cell RAM (count word at address 0,
// particles at 1..count) and streams each position word out on a
// valid/ready interface, using a small skid FIFO to absorb RAM latency.
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err,
  output logic [2:0]            dbg_state
);

  // Handshake: a word transfers in every cycle where out_valid & out_ready
  // are both high; out_pos/out_index/out_last hold while out_valid=1 and
  // out_ready=0, and out_valid never drops until the word is taken.

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_CNT   = 3'd1;
  localparam logic [2:0] S_WAIT_CNT = 3'd2;
  localparam logic [2:0] S_STREAM   = 3'd3;
  localparam logic [2:0] S_FINISH   = 3'd4;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT  = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [PTR_W-1:0]      LAST_SLOT  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W:0]        DEPTH_CRED = (OCC_W + 1)'(FIFO_DEPTH);

  logic [2:0]            r_state;
  logic                  r_wait;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic                  r_count_err;

  // Two-stage tracker matching the RAM read latency
  logic                  r_s1_vld, r_s2_vld;
  logic [ADDR_WIDTH-1:0] r_s1_addr, r_s2_addr;

  // Skid FIFO
  logic [DATA_WIDTH-1:0] r_fifo_pos  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_idx  [FIFO_DEPTH];
  logic                  r_fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;

  logic [ADDR_WIDTH-1:0] w_cnt_word;
  logic [OCC_W:0]        w_outstanding;
  logic                  w_credit_ok;
  logic                  w_issue;
  logic                  w_cnt_rd;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  assign w_cnt_word = mem_q[ADDR_WIDTH-1:0];

  // Reads in flight plus words buffered must stay below the FIFO depth so
  // every returning RAM word has a slot, whatever the consumer does.
  assign w_outstanding = (OCC_W + 1)'(r_s1_vld) + (OCC_W + 1)'(r_s2_vld)
                       + (OCC_W + 1)'(r_occ);
  assign w_credit_ok   = (w_outstanding < DEPTH_CRED);
  assign w_issue       = (r_state == S_STREAM) && (r_next_addr <= r_count) && w_credit_ok;
  assign w_cnt_rd      = (r_state == S_RD_CNT);

  assign mem_rden    = w_issue | w_cnt_rd;
  assign mem_address = w_cnt_rd ? '0 : (w_issue ? r_next_addr : r_addr_hold);
  assign mem_wren    = 1'b0;
  assign mem_data    = '0;

  assign out_valid = (r_occ != '0);
  assign out_pos   = r_fifo_pos[r_rd_ptr];
  assign out_index = r_fifo_idx[r_rd_ptr];
  assign out_last  = out_valid & r_fifo_last[r_rd_ptr];
  assign w_push    = r_s2_vld;
  assign w_pop     = out_valid & out_ready;

  assign busy      = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done      = (r_state == S_FINISH);
  assign count_err = r_count_err;
  assign dbg_state = r_state;

  // Control FSM: count read, count latch/clamp, streaming, completion
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait      <= 1'b0;
      r_count     <= '0;
      r_next_addr <= '0;
      r_count_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RD_CNT;
            r_count_err <= 1'b0;
          end
        end
        S_RD_CNT: begin
          r_state <= S_WAIT_CNT;
          r_wait  <= 1'b0;
        end
        S_WAIT_CNT: begin
          if (!r_wait) begin
            r_wait <= 1'b1;
          end else begin
            if (w_cnt_word > MAX_COUNT) begin
              r_count_err <= 1'b1;
              r_count     <= MAX_COUNT;
            end else begin
              r_count <= w_cnt_word;
            end
            r_next_addr <= ADDR_WIDTH'(1);
            r_state     <= (w_cnt_word == '0) ? S_FINISH : S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_issue) r_next_addr <= r_next_addr + 1'b1;
          if (w_pop && out_last) r_state <= S_FINISH;
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Remember the last driven RAM address so it holds between reads
  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_addr_hold <= '0;
    else if (mem_rden) r_addr_hold <= mem_address;
  end

  // Follow each particle read through the RAM's two-cycle latency
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s1_addr <= '0;
      r_s2_addr <= '0;
    end else begin
      r_s1_vld  <= w_issue;
      r_s1_addr <= w_issue ? r_next_addr : r_s1_addr;
      r_s2_vld  <= r_s1_vld;
      r_s2_addr <= r_s1_addr;
    end
  end

  // Skid FIFO: capture returning words, release them on handshake
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pos[i]  <= '0;
        r_fifo_idx[i]  <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_pos[r_wr_ptr]  <= mem_q;
        r_fifo_idx[r_wr_ptr]  <= r_s2_addr;
        r_fifo_last[r_wr_ptr] <= (r_s2_addr == r_count);
        r_wr_ptr              <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: doc/pos_cell_reader.md
# pos_cell_reader

Streams the contents of one position cell memory out to the force-evaluation pipeline. On a start pulse it reads the particle count from address 0, then reads addresses 1..count. It presents each {posz, posy, posx} word on a valid/ready stream. It sits between a `cell_x_y_z` position RAM (single-port, 2-cycle read latency) and the pair-filter / force pipeline, and is the initiator of that RAM's read interface.

## Interface
Parameters:
- DATA_WIDTH, 96, position word width {posz, posy, posx}, 32 bits each.
- PARTICLE_NUM, 220, RAM depth in words, including the count word at address 0.
- ADDR_WIDTH, 8, RAM address width.
- FIFO_DEPTH, 4, output skid buffer depth; must be ≥ 3 (read latency + 1).

Ports:
- clock  in  1  single clock for block and RAM.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begin reading the cell. Ignored while busy=1.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_rden  out  1  RAM read enable.
- mem_wren  out  1  RAM write enable; constant 0.
- mem_data  out  DATA_WIDTH  RAM write data; constant 0.
- mem_q  in  DATA_WIDTH  RAM read data, valid 2 cycles after the mem_rden cycle.
- out_pos  out  DATA_WIDTH  particle position word.
- out_index  out  ADDR_WIDTH  RAM address the word came from (1..count).
- out_valid  out  1  out_pos, out_index and out_last are valid.
- out_last  out  1  word is the final particle of the cell.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted, or after a zero-count read.
- count_err  out  1  sticky until next accepted start; count exceeded PARTICLE_NUM-1.

## Operation
The state machine has five states: IDLE, RD_CNT, WAIT_CNT, STREAM, FINISH.

- IDLE: on start=1, go to RD_CNT and set busy=1.
- RD_CNT: drive mem_rden=1, mem_address=0 for one cycle. Go to WAIT_CNT.
- WAIT_CNT: wait 2 cycles, then latch count = mem_q[ADDR_WIDTH-1:0].
  - If count > PARTICLE_NUM-1: set count_err=1 and clamp count to PARTICLE_NUM-1.
  - If count == 0: go to FINISH.
  - Otherwise set next_addr=1 and go to STREAM.
- STREAM: issue a read (mem_rden=1, mem_address=next_addr, next_addr++) in any cycle where both hold:
  - next_addr ≤ count, and
  - in_flight + fifo_occupancy < FIFO_DEPTH.
- Read tracking: a 2-stage valid/address shift register follows each issued read. When it exits stage 2, {mem_q, address, address==count} is pushed into the FIFO.
- FIFO head drives out_*. The head is popped on out_valid & out_ready.
- STREAM exits to FINISH when the word with out_last=1 is accepted.
- FINISH: pulse done=1, clear busy, return to IDLE.
- When not issuing a read, mem_rden=0 and mem_address holds its last value.
- Credit rule: the FIFO never overflows, so mem_q is never dropped regardless of out_ready.
- Widths: next_addr and count are ADDR_WIDTH bits. next_addr never wraps, because count ≤ PARTICLE_NUM-1 < 2^ADDR_WIDTH.

## Timing
- Reset values (asynchronous):
  - state=IDLE
  - mem_rden=0, mem_address=0
  - out_valid=0, out_last=0, out_pos=0, out_index=0
  - busy=0, done=0, count_err=0
  - FIFO empty, in-flight pipeline cleared
- Reset mid-operation aborts the read. RAM data still arriving after reset is discarded, because the tracking pipeline is cleared.
- Start accepted in cycle T:
  - count read in T+1.
  - count latched at end of T+3.
  - first particle read in T+4.
  - first out_valid at T+7 (FIFO registered output).
- Steady state with out_ready=1: one word per cycle, no bubbles.
- out_ready low: issue stalls once FIFO_DEPTH words are outstanding. It resumes the cycle after a pop.
- Handshake: out_pos, out_index and out_last are stable while out_valid=1 and out_ready=0.
- Zero count: done pulses at T+4; out_valid is never asserted.
- start arriving while busy=1 or during the done cycle is ignored.
- done and a new start in the same cycle: the start is ignored.

## Test plan
- Count=3 at addr 0, words A,B,C at addr 1..3, out_ready=1:
  - reads at addr 0,1,2,3.
  - out_index 1,2,3 on consecutive cycles starting T+7.
  - out_last only with C.
  - done one cycle after C is accepted.
- Count=0: no out_valid, done=1 at T+4, busy low afterward.
- Count=10, out_ready toggles 1-0-0-1 repeating:
  - all 10 words delivered in order with no loss or duplication.
  - mem_rden never asserted while in_flight+occupancy=4.
- Count word=250 with PARTICLE_NUM=220: count_err=1, exactly 219 words streamed, last out_index=219.
- rst asserted 2 cycles into STREAM with reads in flight:
  - all outputs zero immediately.
  - no out_valid afterward.
  - a subsequent start streams the cell correctly from index 1.
- start pulsed again mid-stream: ignored, and the stream completes unchanged.
